load_store_unit: RTL
====================

# load_store_unit

Initiator-side controller for the single-port `dataMemory`. It accepts one load or store request at a time from the datapath over a valid/ready handshake and drives the memory's `address`/`write_data`/`memwrite`/`memread` port. Byte and halfword stores are performed as read-modify-write on the aligned word. Loads are returned sign- or zero-extended over a valid/ready response channel.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, memory word width (fixed at 32; byte-lane logic assumes 4 lanes)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `req_signed`  in  1  loads only: sign-extend when 1
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  DATA_W  store data, right-aligned
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  datapath takes response
- `resp_rdata`  out  DATA_W  load result (0 for stores)
- `resp_err`  out  1  misaligned or illegal size; no memory access made
- `address`  out  ADDR_W  to memory: word-aligned address, bits [1:0] always 0
- `write_data`  out  DATA_W  to memory
- `memwrite`  out  1  to memory: write strobe
- `memread`  out  1  to memory: read enable
- `read_data`  in  DATA_W  from memory: combinational read of `address` while `memread`=1

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch all request fields. Next state:
  - RESP with `resp_err`=1 if illegal (size 11, half with addr[0]=1, word with addr[1:0]≠0).
  - READ for a load or a sub-word store.
  - WRITE for a word store.
- READ: `memread`=1, `address`={addr[31:2],2'b00}. At the clock edge, sample `read_data`.
  - Load → RESP. Extract lane addr[1:0] (byte) or addr[1] (half), then extend per `req_signed`.
  - Sub-word store → WRITE. Merge the store bytes into the sampled word; other lanes are unchanged.
- WRITE: `memwrite`=1, `write_data` = merged word (sub-word store) or `req_wdata` (word store). Next state: RESP.
- RESP: `resp_valid`=1, outputs held stable until `resp_ready`. Then IDLE.
- `memread` and `memwrite` are never both 1. Both are 0 in IDLE and RESP.
- Byte lanes are little-endian: lane k = bits [8k+7:8k].

## Timing
- Reset: state IDLE. `req_ready`=1; `resp_valid`, `resp_err`, `memwrite`, `memread` = 0; `address`, `write_data`, `resp_rdata` = 0.
- `memwrite` and `memread` are gated by `rst_n`. A reset asserted while in WRITE produces no memory write on that edge. The operation is dropped and no response is given.
- Latency from accept edge T to first `resp_valid` cycle:
  - error: T+1
  - word store: T+2
  - load: T+2
  - sub-word store: T+3
- `req_ready` is 0 from T+1 until the cycle after the response handshake. No new request is accepted in the cycle `resp_valid`&`resp_ready` occur.
- `resp_ready` held low: RESP persists indefinitely with all outputs stable.
- The `read_data` sample uses only the value present in the READ cycle.

## Structure
- Shared package/header `lsu_defs`: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and state encodings.
- One sub-module, `lsu_lane_align`: purely combinational.
  - Extracts and extends on load.
  - Merges store data into the word on store.
- FSM and registers live in `load_store_unit`.

## Test plan
- Word store addr 0x10, data 0xDEADBEEF, then word load 0x10:
  - store: `memwrite` for exactly one cycle with `address`=0x10; `resp_valid` at T+2.
  - load: `resp_rdata`=0xDEADBEEF.
- Byte store 0xA5 to 0x13 over word 0x11223344:
  - READ then WRITE cycles; `write_data`=0xA5223344.
  - signed byte load of 0x13 → 0xFFFFFFA5; unsigned → 0x000000A5.
- Half load 0x12 of word 0x8001_0000:
  - signed → 0xFFFF8001; unsigned → 0x00008001.
- Misaligned word load at 0x06 and size 11:
  - `resp_err`=1 at T+1; `resp_rdata`=0; `memread`/`memwrite` never asserted.
- `resp_ready` held 0 for 5 cycles after a load:
  - `resp_valid` and `resp_rdata` stable; `req_ready`=0 throughout.
  - back-to-back request accepted only after the handshake.
- `rst_n` low during WRITE of a store to 0x20:
  - no `memwrite` on the reset edge; a later load of 0x20 returns the old value.
  - all outputs at reset values next cycle.

Source files
------------

// File: rtl/lsu_defs_pkg.sv
// lsu_defs: shared encodings for the load/store unit.
//   - request size codes (SZ_*)
//   - FSM state type (lsu_state_e)
//   - req_illegal(): size/alignment legality of a request
package lsu_defs;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRead  = 2'b01,
    StWrite = 2'b10,
    StResp  = 2'b11
  } lsu_state_e;

  // A request is rejected without touching memory when the size code is
  // reserved or the address is not naturally aligned for the size.
  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] offset);
    return (size == SZ_ILLEGAL) ||
           ((size == SZ_HALF) && offset[0]) ||
           ((size == SZ_WORD) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for the load/store unit.
// Lanes are little-endian (lane k = bits [8k+7:8k]).
//   i_size      : size code (SZ_BYTE / SZ_HALF / SZ_WORD)
//   i_signed    : sign-extend loaded byte/half when 1
//   i_offset    : byte address bits [1:0]
//   i_word      : aligned memory word
//   i_wdata     : low 16 bits of right-aligned store data
//   o_load_data : selected lane(s), extended to 32 bits
//   o_merged    : i_word with the store lane(s) replaced
module lsu_lane_align
  import lsu_defs::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_word,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte      = i_word[{i_offset, 3'b000} +: 8];
    w_half      = i_word[{i_offset[1], 4'b0000} +: 16];
    o_load_data = i_word;
    o_merged    = i_word;
    case (i_size)
      SZ_BYTE: begin
        o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
        o_merged[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load_data = {{16{i_signed & w_half[15]}}, w_half};
        o_merged[{i_offset[1], 4'b0000} +: 16] = i_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: initiator-side controller for a single-port data memory.
// Accepts one load/store at a time (req_* valid/ready), performs sub-word
// stores as read-modify-write, and returns results on resp_* valid/ready.
//   clk, rst_n      : clock, synchronous active-low reset
//   req_*           : request channel (write, size, signed, addr, wdata)
//   resp_*          : response channel (rdata, err)
//   address         : word-aligned memory address
//   write_data      : memory write data
//   memwrite/memread: memory strobes, never both high, gated by rst_n
//   read_data       : combinational memory read data
module load_store_unit
  import lsu_defs::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              memwrite,
  output logic              memread,
  input  logic [DATA_W-1:0] read_data
);

  lsu_state_e        r_state;
  lsu_state_e        w_state_next;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  // Holds req_wdata, then the merged word once a sub-word store has read.
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic              w_req_illegal;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_merged;

  assign w_req_illegal = req_illegal(req_size, req_addr[1:0]);

  lsu_lane_align u_lane_align (
    .i_size      (r_size),
    .i_signed    (r_signed),
    .i_offset    (r_addr[1:0]),
    .i_word      (read_data),
    .i_wdata     (r_wdata[15:0]),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          if (w_req_illegal) begin
            w_state_next = StResp;
          end else if (req_write && (req_size == SZ_WORD)) begin
            w_state_next = StWrite;
          end else begin
            w_state_next = StRead;
          end
        end
      end
      StRead:  w_state_next = r_write ? StWrite : StResp;
      StWrite: w_state_next = StResp;
      StResp:  w_state_next = resp_ready ? StIdle : StResp;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_write  <= 1'b0;
      r_size   <= SZ_BYTE;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_rdata  <= '0;
            r_err    <= w_req_illegal;
          end
        end
        StRead: begin
          if (r_write) begin
            r_wdata <= w_merged;
          end else begin
            r_rdata <= w_load_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready  = (r_state == StIdle);
    resp_valid = (r_state == StResp);
    resp_err   = (r_state == StResp) && r_err;
    resp_rdata = r_rdata;
    address    = {r_addr[ADDR_W-1:2], 2'b00};
    write_data = r_wdata;
    // Strobes drop combinationally with reset so a reset edge never writes.
    memread    = rst_n && (r_state == StRead);
    memwrite   = rst_n && (r_state == StWrite);
  end

endmodule
